// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the five-stage MIPS pipeline: tracks E/M/W
// producers, drives the D/E/M forwarding selects, the D-stage stall and a stall counter.
module hazard_forward_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic        we_D,
  input  logic [4:0]  dest_D,
  input  logic [1:0]  kind_D,
  output logic        stall,
  output logic [3:0]  fwd_rs_D,
  output logic [3:0]  fwd_rt_D,
  output logic [3:0]  fwd_rs_E,
  output logic [3:0]  fwd_rt_E,
  output logic        fwd_rt_M,
  output logic [31:0] stall_cnt
);

  localparam int unsigned REG_W  = 5;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned KIND_W = 2;
  localparam int unsigned CNT_W  = 32;

  localparam logic [KIND_W-1:0] KIND_LOAD = 2'b01;
  localparam logic [KIND_W-1:0] KIND_PC8  = 2'b10;
  localparam logic [1:0]        TUSE_NONE = 2'd3;

  localparam logic [SEL_W-1:0] SEL_NONE  = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_W_RES = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_M_RES = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_M_PC8 = 4'b0011;
  localparam logic [SEL_W-1:0] SEL_E_PC8 = 4'b0100;

  // Only the slot fields that some decision actually reads are kept.
  logic [REG_W-1:0]  e_dest_q, e_dest_d;
  logic [KIND_W-1:0] e_kind_q, e_kind_d;
  logic [REG_W-1:0]  e_rs_q, e_rs_d;
  logic [REG_W-1:0]  e_rt_q, e_rt_d;
  logic [REG_W-1:0]  m_dest_q;
  logic [KIND_W-1:0] m_kind_q;
  logic [REG_W-1:0]  m_rt_q;
  logic [REG_W-1:0]  w_dest_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic [1:0] tnew_e_c;
  logic [1:0] tnew_m_c;

  function automatic logic is_alu(input logic [KIND_W-1:0] k);
    return (k != KIND_LOAD) && (k != KIND_PC8);
  endfunction

  // M/W select shared by the D and E stages; an M load shadows anything older.
  function automatic logic [SEL_W-1:0] sel_mw(input logic [REG_W-1:0]  r,
                                              input logic [REG_W-1:0]  m_dest,
                                              input logic [KIND_W-1:0] m_kind,
                                              input logic [REG_W-1:0]  w_dest);
    logic [SEL_W-1:0] s;
    s = SEL_NONE;
    if (r == '0) begin
      s = SEL_NONE;
    end else if (m_dest == r) begin
      if (m_kind == KIND_PC8)  s = SEL_M_PC8;
      else if (is_alu(m_kind)) s = SEL_M_RES;
    end else if (w_dest == r) begin
      s = SEL_W_RES;
    end
    return s;
  endfunction

  function automatic logic [SEL_W-1:0] sel_d(input logic [REG_W-1:0] r);
    logic [SEL_W-1:0] s;
    s = SEL_NONE;
    if (r == '0) begin
      s = SEL_NONE;
    end else if (e_dest_q == r) begin
      s = (e_kind_q == KIND_PC8) ? SEL_E_PC8 : SEL_NONE;
    end else begin
      s = sel_mw(r, m_dest_q, m_kind_q, w_dest_q);
    end
    return s;
  endfunction

  function automatic logic op_stall(input logic [REG_W-1:0] r, input logic [1:0] tuse);
    return (tuse != TUSE_NONE) && (r != '0) &&
           (((e_dest_q == r) && (tnew_e_c > tuse)) ||
            ((m_dest_q == r) && (tnew_m_c > tuse)));
  endfunction

  always_comb begin
    tnew_e_c = 2'd1;
    if (e_kind_q == KIND_LOAD)     tnew_e_c = 2'd2;
    else if (e_kind_q == KIND_PC8) tnew_e_c = 2'd0;
    tnew_m_c = (m_kind_q == KIND_LOAD) ? 2'd1 : 2'd0;
  end

  assign stall     = op_stall(rs_D, tuse_rs_D) || op_stall(rt_D, tuse_rt_D);
  assign fwd_rs_D  = sel_d(rs_D);
  assign fwd_rt_D  = sel_d(rt_D);
  assign fwd_rs_E  = sel_mw(e_rs_q, m_dest_q, m_kind_q, w_dest_q);
  assign fwd_rt_E  = sel_mw(e_rt_q, m_dest_q, m_kind_q, w_dest_q);
  assign fwd_rt_M  = (m_rt_q != '0) && (w_dest_q == m_rt_q);
  assign stall_cnt = stall_cnt_q;

  // E slot takes a bubble on stall; a non-writing instruction is tracked with dest 0.
  always_comb begin
    e_dest_d = '0;
    e_kind_d = '0;
    e_rs_d   = '0;
    e_rt_d   = '0;
    if (!stall) begin
      e_dest_d = we_D ? dest_D : '0;
      e_kind_d = kind_D;
      e_rs_d   = rs_D;
      e_rt_d   = rt_D;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_dest_q    <= '0;
      e_kind_q    <= '0;
      e_rs_q      <= '0;
      e_rt_q      <= '0;
      m_dest_q    <= '0;
      m_kind_q    <= '0;
      m_rt_q      <= '0;
      w_dest_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_dest_q <= e_dest_d;
      e_kind_q <= e_kind_d;
      e_rs_q   <= e_rs_d;
      e_rt_q   <= e_rt_d;
      m_dest_q <= e_dest_q;
      m_kind_q <= e_kind_q;
      m_rt_q   <= e_rt_q;
      w_dest_q <= m_dest_q;
      if (stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: directed instruction sequences push
// expected outputs; a negedge monitor pops and compares them.
module tb_hazard_forward_ctrl;

  localparam logic [1:0] KALU = 2'b00;
  localparam logic [1:0] KLD  = 2'b01;
  localparam logic [1:0] KPC8 = 2'b10;
  localparam logic [3:0] Z    = 4'b0000;
  localparam logic [3:0] SW   = 4'b0001;
  localparam logic [3:0] SM   = 4'b0010;
  localparam logic [3:0] SMPC = 4'b0011;
  localparam logic [3:0] SEPC = 4'b0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  rs_D, rt_D, dest_D;
  logic [1:0]  tuse_rs_D, tuse_rt_D, kind_D;
  logic        we_D;
  logic        stall, fwd_rt_M;
  logic [3:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_forward_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .we_D(we_D), .dest_D(dest_D), .kind_D(kind_D),
    .stall(stall), .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic [15:0] id;
    logic        st;
    logic [3:0]  rsd, rtd, rse, rte;
    logic        rtm;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic cmp(input string nm, input logic [15:0] id, input logic [31:0] got,
                     input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s step %0d: got %0h expected %0h", nm, id, got, want);
  endtask

  // Monitor: outputs are combinational, so every pushed entry is judged mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      cmp("stall",     cur.id, 32'(stall),     32'(cur.st));
      cmp("fwd_rs_D",  cur.id, 32'(fwd_rs_D),  32'(cur.rsd));
      cmp("fwd_rt_D",  cur.id, 32'(fwd_rt_D),  32'(cur.rtd));
      cmp("fwd_rs_E",  cur.id, 32'(fwd_rs_E),  32'(cur.rse));
      cmp("fwd_rt_E",  cur.id, 32'(fwd_rt_E),  32'(cur.rte));
      cmp("fwd_rt_M",  cur.id, 32'(fwd_rt_M),  32'(cur.rtm));
      cmp("stall_cnt", cur.id, stall_cnt,      cur.cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] trs,
                       input logic [1:0] trt, input logic we, input logic [4:0] dest,
                       input logic [1:0] kind);
    rs_D = rs; rt_D = rt; tuse_rs_D = trs; tuse_rt_D = trt;
    we_D = we; dest_D = dest; kind_D = kind;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, KALU);
  endtask

  task automatic expect_out(input logic [15:0] id, input logic st, input logic [3:0] rsd,
                            input logic [3:0] rtd, input logic [3:0] rse,
                            input logic [3:0] rte, input logic rtm, input logic [31:0] cnt);
    exp_t e;
    e.id = id; e.st = st; e.rsd = rsd; e.rtd = rtd;
    e.rse = rse; e.rte = rte; e.rtm = rtm; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      tick();
      nop();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    nop();
    // Reset holds everything clear even with a live D consumer.
    tick(); drive(5'd1, 5'd0, 2'd0, 2'd3, 1'b1, 5'd1, KLD);
    expect_out(16'd1, 1'b0, Z, Z, Z, Z, 1'b0, 32'd0);
    tick(); reset_n = 1'b1; nop();

    // ALU -> ALU forwarding
    tick(); drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd1, KALU);
    expect_out(16'd2, 1'b0, Z, Z, Z, Z, 1'b0, 32'd0);
    tick(); drive(5'd1, 5'd0, 2'd1, 2'd3, 1'b1, 5'd2, KALU);
    expect_out(16'd3, 1'b0, Z, Z, Z, Z, 1'b0, 32'd0);
    tick(); nop();
    expect_out(16'd4, 1'b0, Z, Z, SM, Z, 1'b0, 32'd0);
    tick(); drive(5'd1, 5'd0, 2'd1, 2'd3, 1'b0, 5'd0, KALU);
    expect_out(16'd5, 1'b0, SW, Z, Z, Z, 1'b0, 32'd0);
    drain();

    // Load -> branch: two stall cycles
    tick(); drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd3, KLD);
    expect_out(16'd6, 1'b0, Z, Z, Z, Z, 1'b0, 32'd0);
    tick(); drive(5'd3, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, KALU);
    expect_out(16'd7, 1'b1, Z, Z, Z, Z, 1'b0, 32'd0);
    tick();
    expect_out(16'd8, 1'b1, Z, Z, Z, Z, 1'b0, 32'd1);
    tick();
    expect_out(16'd9, 1'b0, SW, Z, Z, Z, 1'b0, 32'd2);
    drain();

    // jal -> jr link forwarding
    tick(); drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd31, KPC8);
    expect_out(16'd10, 1'b0, Z, Z, Z, Z, 1'b0, 32'd2);
    tick(); drive(5'd31, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, KALU);
    expect_out(16'd11, 1'b0, SEPC, Z, Z, Z, 1'b0, 32'd2);
    tick(); nop();
    expect_out(16'd12, 1'b0, Z, Z, SMPC, Z, 1'b0, 32'd2);
    drain();

    // lw -> sw store data forwarded in M
    tick(); drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd4, KLD);
    expect_out(16'd13, 1'b0, Z, Z, Z, Z, 1'b0, 32'd2);
    tick(); drive(5'd0, 5'd4, 2'd3, 2'd2, 1'b0, 5'd0, KALU);
    expect_out(16'd14, 1'b0, Z, Z, Z, Z, 1'b0, 32'd2);
    tick(); nop();
    expect_out(16'd15, 1'b0, Z, Z, Z, Z, 1'b0, 32'd2);
    tick(); nop();
    expect_out(16'd16, 1'b0, Z, Z, Z, Z, 1'b1, 32'd2);
    drain();

    // $0 is never forwarded
    tick(); drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, KALU);
    expect_out(16'd17, 1'b0, Z, Z, Z, Z, 1'b0, 32'd2);
    tick(); drive(5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, KALU);
    expect_out(16'd18, 1'b0, Z, Z, Z, Z, 1'b0, 32'd2);

    // Two writers of $5: the younger (M) wins over W
    tick(); drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd5, KALU);
    expect_out(16'd19, 1'b0, Z, Z, Z, Z, 1'b0, 32'd2);
    tick(); drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd5, KALU);
    expect_out(16'd20, 1'b0, Z, Z, Z, Z, 1'b0, 32'd2);
    tick(); nop();
    tick(); drive(5'd5, 5'd5, 2'd1, 2'd1, 1'b0, 5'd0, KALU);
    expect_out(16'd21, 1'b0, SM, SM, Z, Z, 1'b0, 32'd2);
    tick(); nop();
    expect_out(16'd22, 1'b0, Z, Z, SW, SW, 1'b0, 32'd2);
    drain();

    // Reset asserted in the middle of a load-use stall
    tick(); drive(5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd1, KLD);
    expect_out(16'd23, 1'b0, Z, Z, Z, Z, 1'b0, 32'd2);
    tick(); drive(5'd1, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, KALU);
    expect_out(16'd24, 1'b1, Z, Z, Z, Z, 1'b0, 32'd2);
    tick(); reset_n = 1'b0;
    expect_out(16'd25, 1'b0, Z, Z, Z, Z, 1'b0, 32'd0);
    tick(); reset_n = 1'b1;
    expect_out(16'd26, 1'b0, Z, Z, Z, Z, 1'b0, 32'd0);
    tick();
    expect_out(16'd27, 1'b0, Z, Z, Z, Z, 1'b0, 32'd0);

    tick(); tick();
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
